// File: rtl/tinker_pkg.sv
// Shared definitions for the tinker_core CPU: opcodes, field positions, FSM states.
package tinker_pkg;
  localparam int XLEN = 64;

  // Instruction field bit positions (inclusive ranges)
  localparam int OP_MSB = 31, OP_LSB = 27;
  localparam int RD_MSB = 26, RD_LSB = 22;
  localparam int RS_MSB = 21, RS_LSB = 17;
  localparam int RT_MSB = 16, RT_LSB = 12;
  localparam int L_MSB  = 11, L_LSB  = 0;

  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTL  = 5'h06;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_HALT   = 5'h0F;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_ADDI   = 5'h19;
  localparam logic [4:0] OP_SUB    = 5'h1A;
  localparam logic [4:0] OP_SUBI   = 5'h1B;
  localparam logic [4:0] OP_MUL    = 5'h1C;
  localparam logic [4:0] OP_DIV    = 5'h1D;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALTED    = 3'd4
  } state_e;

  // True for opcodes that produce a register result; everything else is a NOP
  // (halt is handled separately by the FSM).
  function automatic logic writes_rd(input logic [4:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHFTR, OP_SHFTRI, OP_SHFTL, OP_SHFTLI,
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV: writes_rd = 1'b1;
      default:                                          writes_rd = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/tinker_core_memory.sv
// Unified byte-addressed memory with a 32-bit little-endian read port; addresses wrap.
module memory #(
  parameter int MEM_BYTES = 524288,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [7:0] bytes [0:MEM_BYTES-1];

  // Byte store port; contents are never touched by reset.
  always_ff @(posedge clk) begin
    if (we_i) bytes[waddr_i] <= wdata_i;
  end

  assign rdata_o = {bytes[raddr_i + AW'(3)], bytes[raddr_i + AW'(2)],
                    bytes[raddr_i + AW'(1)], bytes[raddr_i]};
endmodule

// File: rtl/tinker_core_reg_file.sv
// 32 x 64-bit register file: two combinational read ports, one synchronous write port.
module reg_file
  import tinker_pkg::*;
#(
  parameter int MEM_BYTES = 524288
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra_i,
  input  logic [4:0]      rb_i,
  output logic [XLEN-1:0] rda_o,
  output logic [XLEN-1:0] rdb_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);
  logic [XLEN-1:0] registers [0:31];

  assign rda_o = registers[ra_i];
  assign rdb_o = registers[rb_i];

  // Reset clears r0..r30 and points the stack pointer r31 at the top of memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) registers[i] <= '0;
      registers[31] <= XLEN'(MEM_BYTES);
    end else if (we_i) begin
      registers[wa_i] <= wd_i;
    end
  end
endmodule

// File: rtl/tinker_core.sv
// Multicycle Tinker-subset core: FETCH -> DECODE -> EXECUTE -> WRITEBACK, one instruction per 4 cycles.
module tinker_core
  import tinker_pkg::*;
#(
  parameter int              MEM_BYTES = 524288,
  parameter logic [XLEN-1:0] RESET_PC  = 64'h2000
) (
  input  logic clk,
  input  logic reset,
  output logic hlt
);
  localparam int AW = $clog2(MEM_BYTES);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            hlt_q;
  logic [31:0]     inst_q;
  logic [4:0]      op_q, rd_q;
  logic [11:0]     l_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic            wen_q, halt_q;

  logic [31:0]     fetch_word;
  logic [XLEN-1:0] rs_val, rt_val;
  logic [XLEN-1:0] alu_d;
  logic            rf_we;

  memory #(.MEM_BYTES(MEM_BYTES)) memory (
    .clk     (clk),
    .we_i    (1'b0),
    .waddr_i ('0),
    .wdata_i (8'h00),
    .raddr_i (pc_q[AW-1:0]),
    .rdata_o (fetch_word)
  );

  // Register write only on the WRITEBACK edge; reset suppresses any pending write.
  assign rf_we = (state_q == WRITEBACK) && wen_q && !reset;

  reg_file #(.MEM_BYTES(MEM_BYTES)) reg_file (
    .clk   (clk),
    .reset (reset),
    .ra_i  (inst_q[RS_MSB:RS_LSB]),
    .rb_i  (inst_q[RT_MSB:RT_LSB]),
    .rda_o (rs_val),
    .rdb_o (rt_val),
    .we_i  (rf_we),
    .wa_i  (rd_q),
    .wd_i  (res_q)
  );

  assign hlt = hlt_q;

  // Combinational ALU over the operands latched in DECODE.
  always_comb begin
    logic [XLEN-1:0] imm;
    logic signed [XLEN-1:0] sa, sb;
    imm   = {{(XLEN-12){1'b0}}, l_q};
    sa    = a_q;
    sb    = b_q;
    alu_d = '0;
    case (op_q)
      OP_AND:    alu_d = a_q & b_q;
      OP_OR:     alu_d = a_q | b_q;
      OP_XOR:    alu_d = a_q ^ b_q;
      OP_NOT:    alu_d = ~a_q;
      OP_SHFTR:  alu_d = a_q >> b_q[5:0];
      OP_SHFTRI: alu_d = a_q >> l_q[5:0];
      OP_SHFTL:  alu_d = a_q << b_q[5:0];
      OP_SHFTLI: alu_d = a_q << l_q[5:0];
      OP_ADD:    alu_d = a_q + b_q;
      OP_ADDI:   alu_d = a_q + imm;
      OP_SUB:    alu_d = a_q - b_q;
      OP_SUBI:   alu_d = a_q - imm;
      OP_MUL:    alu_d = a_q * b_q;
      OP_DIV:    alu_d = (b_q == '0) ? '0 : XLEN'(sa / sb);
      default:   alu_d = '0;
    endcase
  end

  // Control FSM with registered outputs; datapath latches carry no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hlt_q   <= 1'b0;
      wen_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          inst_q  <= fetch_word;
          state_q <= DECODE;
        end
        DECODE: begin
          op_q    <= inst_q[OP_MSB:OP_LSB];
          rd_q    <= inst_q[RD_MSB:RD_LSB];
          l_q     <= inst_q[L_MSB:L_LSB];
          a_q     <= rs_val;
          b_q     <= rt_val;
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          res_q   <= alu_d;
          wen_q   <= writes_rd(op_q);
          halt_q  <= (op_q == OP_HALT) && (l_q == 12'd0);
          state_q <= WRITEBACK;
        end
        WRITEBACK: begin
          wen_q <= 1'b0;
          if (halt_q) begin
            hlt_q   <= 1'b1;
            state_q <= HALTED;
          end else begin
            pc_q    <= pc_q + XLEN'(4);
            state_q <= FETCH;
          end
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_tinker_core.sv
// Self-checking bench for tinker_core: directed vector table, random ALU vectors, halt/reset sequences.
module tb_tinker_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hlt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] FILLER = 32'h1100_0000;

  tinker_core cpu (.clk(clk), .reset(reset), .hlt(hlt));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [11:0] l;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] l);
    return {op, rd, rs, rt, l};
  endfunction

  // Reference behaviour: what r0 holds after "op r0,r16,r17" (or L form) runs from r0=0.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [11:0] l);
    longint sa, sb;
    int unsigned sh, shi;
    sa  = a;
    sb  = b;
    sh  = b % 64;
    shi = l % 64;
    case (op)
      5'h00: return a & b;
      5'h01: return a | b;
      5'h02: return a ^ b;
      5'h03: return ~a;
      5'h04: return a >> sh;
      5'h05: return a >> shi;
      5'h06: return a << sh;
      5'h07: return a << shi;
      5'h18: return a + b;
      5'h19: return a + 64'(l);
      5'h1A: return a - b;
      5'h1B: return a - 64'(l);
      5'h1C: return a * b;
      5'h1D: return (b == 0) ? 64'd0 : 64'(sa / sb);
      default: return 64'd0;   // NOP leaves r0 at its poked value of 0
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) cpu.memory.bytes[addr + k] = w[8*k +: 8];
  endtask

  // Reset 5 cycles, load program, poke registers, release reset.
  task automatic start_prog(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [63:0] a, input logic [63:0] b);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int ad = 32'h2000; ad < 32'h2040; ad++) cpu.memory.bytes[ad] = 8'h00;
    put_word(32'h2000, w0);
    put_word(32'h2004, w1);
    put_word(32'h2008, w2);
    for (int r = 0; r < 16; r++) cpu.reg_file.registers[r] = 64'd0;
    cpu.reg_file.registers[16] = a;
    cpu.reg_file.registers[17] = b;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    start_prog(enc(v.op, 5'd0, 5'd16, 5'd17, v.l), FILLER, 32'h0, v.a, v.b);
    repeat (25) @(posedge clk);
    @(negedge clk);
    check(v.name, cpu.reg_file.registers[0], v.exp);
  endtask

  initial begin
    vecs.push_back('{"add",       5'h18, 64'd247, 64'd162, 12'd0, 64'd409});
    vecs.push_back('{"sub",       5'h1A, 64'd100, 64'd40,  12'd0, 64'd60});
    vecs.push_back('{"and",       5'h00, 64'd15,  64'd9,   12'd0, 64'd9});
    vecs.push_back('{"or",        5'h01, 64'd15,  64'd9,   12'd0, 64'd15});
    vecs.push_back('{"xor",       5'h02, 64'd15,  64'd9,   12'd0, 64'd6});
    vecs.push_back('{"not",       5'h03, 64'd7,   64'd0,   12'd0, 64'hFFFF_FFFF_FFFF_FFF8});
    vecs.push_back('{"mul",       5'h1C, 64'd2,   64'd3,   12'd0, 64'd6});
    vecs.push_back('{"div",       5'h1D, 64'd14,  64'd5,   12'd0, 64'd2});
    vecs.push_back('{"div0",      5'h1D, 64'd14,  64'd0,   12'd0, 64'd0});
    vecs.push_back('{"divneg",    5'h1D, -64'sd14, 64'd5,  12'd0, -64'sd2});
    vecs.push_back('{"addi",      5'h19, 64'd20,  64'd0,   12'd5, 64'd25});
    vecs.push_back('{"subi",      5'h1B, 64'd20,  64'd0,   12'd3, 64'd17});
    vecs.push_back('{"subwrap",   5'h1A, 64'd0,   64'd1,   12'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"shftri",    5'h05, 64'h100, 64'd0,   12'hFC4, 64'h10});
    vecs.push_back('{"shftl63",   5'h06, 64'd1,   64'd63,  12'd0, 64'h8000_0000_0000_0000});
    vecs.push_back('{"shftr_mod", 5'h04, 64'h8,   64'd65,  12'd0, 64'h4});
    vecs.push_back('{"nop_op08",  5'h08, 64'd5,   64'd6,   12'd0, 64'd0});
    vecs.push_back('{"halt_l1",   5'h0F, 64'd5,   64'd6,   12'd1, 64'd0});

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hlt", {63'd0, hlt}, 64'd0);
    check("rst_pc", cpu.pc_q, 64'h2000);
    check("rst_r31", cpu.reg_file.registers[31], 64'h80000);
    check("rst_r5", cpu.reg_file.registers[5], 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Random ALU vectors against the reference model
    begin
      logic [4:0] ops [14] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
                               5'h07, 5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D};
      for (int t = 0; t < 24; t++) begin
        vec_t v;
        v.op = ops[$urandom_range(0, 13)];
        v.a  = {$urandom, $urandom};
        v.b  = (t % 4 == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
        if (v.op == 5'h1D && v.a == 64'h8000_0000_0000_0000) v.a = 64'd12345;
        v.l    = 12'($urandom);
        v.exp  = model(v.op, v.a, v.b, v.l);
        v.name = $sformatf("rand%0d_op%02h", t, v.op);
        run_vec(v);
      end
    end

    // Halt: add; halt; add r0,r0,r0 -- the trailing add must never run
    begin
      int cyc;
      logic [63:0] a, b;
      a = 64'd1000; b = 64'd234;
      start_prog(enc(5'h18, 5'd0, 5'd16, 5'd17, 12'd0), enc(5'h0F, 5'd0, 5'd0, 5'd0, 12'd0),
                 enc(5'h18, 5'd0, 5'd0, 5'd0, 12'd0), a, b);
      cyc = 0;
      while (hlt !== 1'b1 && cyc < 8) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
      check("halt_within_8", {63'd0, hlt}, 64'd1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("halt_r0_fixed", cpu.reg_file.registers[0], a + b);
      check("halt_sticky", {63'd0, hlt}, 64'd1);
      check("halt_r4_untouched", cpu.reg_file.registers[4], 64'd0);

      // Reset out of HALTED
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("halt_reset_hlt", {63'd0, hlt}, 64'd0);
      check("halt_reset_pc", cpu.pc_q, 64'h2000);
    end

    // Reset asserted mid-program, then rerun: core restarts at 0x2000
    begin
      start_prog(enc(5'h18, 5'd0, 5'd16, 5'd17, 12'd0), enc(5'h18, 5'd1, 5'd16, 5'd16, 12'd0),
                 FILLER, 64'd3, 64'd4);
      repeat (7) @(posedge clk);   // second instruction in flight
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_hlt", {63'd0, hlt}, 64'd0);
      check("mid_rst_pc", cpu.pc_q, 64'h2000);
      check("mid_rst_r31", cpu.reg_file.registers[31], 64'h80000);
      check("mid_rst_r1", cpu.reg_file.registers[1], 64'd0);
      check("mid_rst_mem", {32'd0, cpu.memory.bytes[32'h2007], cpu.memory.bytes[32'h2006],
                            cpu.memory.bytes[32'h2005], cpu.memory.bytes[32'h2004]},
            {32'd0, enc(5'h18, 5'd1, 5'd16, 5'd16, 12'd0)});
      // Release with registers poked; first result lands within 4 edges
      cpu.reg_file.registers[16] = 64'd3;
      cpu.reg_file.registers[17] = 64'd4;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("restart_first_4edges", cpu.reg_file.registers[0], 64'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("restart_r1", cpu.reg_file.registers[1], 64'd6);
      check("restart_pc", cpu.pc_q, 64'h2008);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
